rst_seq_ctrl: RTL and testbench

Parametrised reset sequencer for the board-level top of the VGA pong design. It holds every downstream block in reset until the clock generator reports lock, stretches reset for a fixed time, then releases NUM_RST reset outputs in a staggered order. Loss of lock or a press of the reset button restarts the whole sequence. It replaces the ad-hoc button-to-rst wiring and the unused power-up shift register in the board top, and sits between the clock wizard and the functional top modules.

---
 rtl/rst_seq_pkg.sv | 37 +++
 rtl/rst_seq_ctrl_btn_debounce.sv | 47 ++++
 rtl/rst_seq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the board-level reset sequencer: sequencer state
// encoding, fault counter width, default cycle constants for a 65 MHz clock
// and the saturating increment used by the lock-loss fault counter.
// ---------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STRETCH   = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } rst_seq_state_e;

    localparam int FAULT_CNT_W = 8;

    // Defaults sized for the 65 MHz pixel clock
    localparam int DEF_NUM_RST         = 4;
    localparam int DEF_STRETCH_CYCLES  = 1024;
    localparam int DEF_STAGGER_CYCLES  = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 650000;   // 10 ms
    localparam int DEF_SYNC_STAGES     = 2;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [FAULT_CNT_W-1:0] fault_inc(input logic [FAULT_CNT_W-1:0] cnt);
        logic [FAULT_CNT_W-1:0] res;
        if (cnt == {FAULT_CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + FAULT_CNT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Level debouncer for an already-synchronised button. The output follows the
// input only after STABLE_CYCLES consecutive samples that differ from the
// current output level; any shorter excursion is discarded.
//
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset (output returns to 0)
//   in   in   synchronised button level
//   out  out  debounced level (registered)
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int STABLE_CYCLES = 650000
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam int                CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r = '0;
    logic             out_r = 1'b0;

    // Count consecutive samples disagreeing with the output; flip on the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            out_r <= 1'b0;
        end else if (in != out_r) begin
            if (cnt_r == LAST) begin
                out_r <= in;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= '0;
        end
    end

    assign out = out_r;

endmodule

// File: rtl/rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rst_seq_ctrl
// Reset sequencer for the board top. Holds all downstream resets until the
// clock generator is locked, stretches reset for STRETCH_CYCLES, then
// releases rst_o bit by bit (bit 0 first) every STAGGER_CYCLES. Loss of lock
// or a button press restarts the whole sequence.
//
// Build option: define RST_SEQ_DEBOUNCE_EN to pass the button through
// btn_debounce (DEBOUNCE_CYCLES stable samples); otherwise the synchronised
// button level is used directly.
//
// Ports:
//   clk          in   single clock
//   rst          in   synchronous active-high reset, highest priority
//   locked_i     in   clock-generator lock (asynchronous)
//   btn_i        in   raw reset button, active-high (asynchronous)
//   rst_o        out  NUM_RST active-high resets, bit 0 releases first
//   ready_o      out  high once every rst_o bit is released
//   fault_cnt_o  out  saturating count of lock losses in STRETCH/RELEASE/RUN
// ---------------------------------------------------------------------------
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_RST         = DEF_NUM_RST,
    parameter int STRETCH_CYCLES  = DEF_STRETCH_CYCLES,
    parameter int STAGGER_CYCLES  = DEF_STAGGER_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   locked_i,
    input  logic                   btn_i,
    output logic [NUM_RST-1:0]     rst_o,
    output logic                   ready_o,
    output logic [FAULT_CNT_W-1:0] fault_cnt_o
);

    // One shared counter serves both the stretch and the stagger phase
    localparam int               CNT_MAX      = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int               CNT_W        = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] lock_sync_r = '0;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] btn_sync_r  = '0;

    logic                   btn_db_s;
    logic                   lock_lvl_r  = 1'b0;
    logic                   btn_lvl_r   = 1'b0;

    rst_seq_state_e         state_r     = ST_HOLD;
    rst_seq_state_e         state_next_s;
    logic [CNT_W-1:0]       cnt_r       = '0;
    logic [CNT_W-1:0]       cnt_next_s;
    logic [NUM_RST-1:0]     rst_r       = {NUM_RST{1'b1}};
    logic [NUM_RST-1:0]     rst_next_s;
    logic [NUM_RST-1:0]     rst_shift_s;
    logic                   ready_r     = 1'b0;
    logic                   ready_next_s;
    logic [FAULT_CNT_W-1:0] fault_r     = '0;
    logic [FAULT_CNT_W-1:0] fault_next_s;
    logic                   active_s;
    logic                   abort_s;

    // Synchroniser chains for the two asynchronous inputs, one flop per stage
    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
        if (i == 0) begin : g_first
            // First stage samples the raw asynchronous pins
            always_ff @(posedge clk) begin
                if (rst) begin
                    lock_sync_r[0] <= 1'b0;
                    btn_sync_r[0]  <= 1'b0;
                end else begin
                    lock_sync_r[0] <= locked_i;
                    btn_sync_r[0]  <= btn_i;
                end
            end
        end else begin : g_next
            // Later stages shift the previous stage along
            always_ff @(posedge clk) begin
                if (rst) begin
                    lock_sync_r[i] <= 1'b0;
                    btn_sync_r[i]  <= 1'b0;
                end else begin
                    lock_sync_r[i] <= lock_sync_r[i-1];
                    btn_sync_r[i]  <= btn_sync_r[i-1];
                end
            end
        end
    end

`ifdef RST_SEQ_DEBOUNCE_EN
    btn_debounce #(
        .STABLE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk (clk),
        .rst (rst),
        .in  (btn_sync_r[SYNC_STAGES-1]),
        .out (btn_db_s)
    );
`else
    assign btn_db_s = btn_sync_r[SYNC_STAGES-1];
`endif

    // Level register between synchronisers and FSM; sets the SYNC_STAGES+1 input latency
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_lvl_r <= 1'b0;
            btn_lvl_r  <= 1'b0;
        end else begin
            lock_lvl_r <= lock_sync_r[SYNC_STAGES-1];
            btn_lvl_r  <= btn_db_s;
        end
    end

    // Next-state, counter, reset pattern and fault count decisions
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        rst_next_s   = rst_r;
        ready_next_s = 1'b0;
        fault_next_s = fault_r;
        // Shifting left clears the lowest still-asserted bit next, keeping release order monotonic
        rst_shift_s  = rst_r << 1;
        active_s     = (state_r == ST_STRETCH) || (state_r == ST_RELEASE) || (state_r == ST_RUN);
        abort_s      = active_s && (!lock_lvl_r || btn_lvl_r);

        if (abort_s) begin
            state_next_s = ST_HOLD;
            cnt_next_s   = '0;
            rst_next_s   = {NUM_RST{1'b1}};
            // Simultaneous button and lock loss still counts as a single fault
            if (!lock_lvl_r) begin
                fault_next_s = fault_inc(fault_r);
            end else begin
                fault_next_s = fault_r;
            end
        end else begin
            case (state_r)
                ST_HOLD: begin
                    state_next_s = ST_WAIT_LOCK;
                    cnt_next_s   = '0;
                    rst_next_s   = {NUM_RST{1'b1}};
                end
                ST_WAIT_LOCK: begin
                    cnt_next_s = '0;
                    rst_next_s = {NUM_RST{1'b1}};
                    // A lock return while the button is held does not start the sequence
                    if (lock_lvl_r && !btn_lvl_r) begin
                        state_next_s = ST_STRETCH;
                    end else begin
                        state_next_s = ST_WAIT_LOCK;
                    end
                end
                ST_STRETCH, ST_RELEASE: begin
                    if (cnt_r == ((state_r == ST_STRETCH) ? STRETCH_LAST : STAGGER_LAST)) begin
                        cnt_next_s = '0;
                        rst_next_s = rst_shift_s;
                        if (rst_shift_s == {NUM_RST{1'b0}}) begin
                            state_next_s = ST_RUN;
                        end else begin
                            state_next_s = ST_RELEASE;
                        end
                    end else begin
                        cnt_next_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    rst_next_s   = {NUM_RST{1'b0}};
                    ready_next_s = 1'b1;
                end
                default: begin
                    state_next_s = ST_HOLD;
                    cnt_next_s   = '0;
                    rst_next_s   = {NUM_RST{1'b1}};
                end
            endcase
        end
    end

    // State and registered outputs; rst overrides every other event
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_HOLD;
            cnt_r   <= '0;
            rst_r   <= {NUM_RST{1'b1}};
            ready_r <= 1'b0;
            fault_r <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            rst_r   <= rst_next_s;
            ready_r <= ready_next_s;
            fault_r <= fault_next_s;
        end
    end

    assign rst_o       = rst_r;
    assign ready_o     = ready_r;
    assign fault_cnt_o = fault_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_ctrl
// Directed bench for rst_seq_ctrl with NUM_RST=4, STRETCH_CYCLES=8,
// STAGGER_CYCLES=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=5. Inputs change and
// outputs are sampled on the falling clock edge. Expected rst_o/ready_o are
// derived from the documented latencies relative to the rising edge that
// first samples a changed input.
// ---------------------------------------------------------------------------
module tb_rst_seq_ctrl;
    import rst_seq_pkg::*;

    localparam int NUM_RST  = 4;
    localparam int STRETCH  = 8;
    localparam int STAGGER  = 4;
    localparam int SYNC     = 2;
    localparam int DEBOUNCE = 5;
    // STRETCH entry edge -> ready_o rise
    localparam int SEQ_READY = STRETCH + STAGGER * (NUM_RST - 1) + 1;
    localparam int NEVER     = 1000;
`ifdef RST_SEQ_DEBOUNCE_EN
    localparam int BTN_LAT      = SYNC + 1 + DEBOUNCE;
    localparam int GLITCH_ABORT = -1;
`else
    localparam int BTN_LAT      = SYNC + 1;
    localparam int GLITCH_ABORT = BTN_LAT;
`endif

    logic                   clk      = 1'b0;
    logic                   rst      = 1'b1;
    logic                   locked_i = 1'b0;
    logic                   btn_i    = 1'b0;
    logic [NUM_RST-1:0]     rst_o;
    logic                   ready_o;
    logic [FAULT_CNT_W-1:0] fault_cnt_o;

    int n_vec     = 0;
    int n_err     = 0;
    int exp_fault = 0;

    rst_seq_ctrl #(
        .NUM_RST         (NUM_RST),
        .STRETCH_CYCLES  (STRETCH),
        .STAGGER_CYCLES  (STAGGER),
        .DEBOUNCE_CYCLES (DEBOUNCE),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .locked_i    (locked_i),
        .btn_i       (btn_i),
        .rst_o       (rst_o),
        .ready_o     (ready_o),
        .fault_cnt_o (fault_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset pattern j cycles after the reference edge when STRETCH is entered at edge s
    function automatic logic [NUM_RST-1:0] seq_rst(input int j, input int s);
        logic [NUM_RST-1:0] r;
        for (int k = 0; k < NUM_RST; k++) begin
            r[k] = (j < s + STRETCH + STAGGER * k);
        end
        return r;
    endfunction

    // Observe n cycles after the reference edge. Before abort_at the block is
    // expected running (all released, ready); from abort_at on it follows the
    // sequence restarting at edge restart_at. btn_i drops after btn_len samples.
    task automatic watch(input string tag, input int n, input int abort_at,
                         input int restart_at, input int btn_len);
        for (int j = 0; j < n; j++) begin
            logic [NUM_RST-1:0] er;
            logic               eready;
            @(negedge clk);
            if (abort_at >= 0 && j >= abort_at) begin
                er     = seq_rst(j, restart_at);
                eready = (j >= restart_at + SEQ_READY);
            end else begin
                er     = {NUM_RST{1'b0}};
                eready = 1'b1;
            end
            check_eq($sformatf("%s rst_o@%0d", tag, j), 32'(rst_o), 32'(er));
            check_eq($sformatf("%s ready_o@%0d", tag, j), 32'(ready_o), 32'(eready));
            if (j == btn_len - 1) btn_i = 1'b0;
        end
    endtask

    task automatic check_fault(input string tag);
        check_eq(tag, 32'(fault_cnt_o), 32'(exp_fault));
    endtask

    initial begin
        // Reset state
        idle(3);
        check_eq("reset rst_o", 32'(rst_o), 32'hF);
        check_eq("reset ready_o", 32'(ready_o), 32'h0);
        check_fault("reset fault");
        rst = 1'b0;
        idle(3);
        check_eq("wait_lock rst_o", 32'(rst_o), 32'hF);

        // Normal bring-up: releases at t+11/15/19/23, ready at t+24
        locked_i = 1'b1;
        watch("bringup", 28, 0, SYNC + 1, 0);
        check_fault("bringup fault");

        // Lock loss in RUN: all high at u+3, one fault, then full re-sequence
        locked_i = 1'b0;
        exp_fault++;
        watch("lockloss", 6, SYNC + 1, NEVER, 0);
        check_fault("lockloss fault");
        idle(3);
        locked_i = 1'b1;
        watch("relock", 28, 0, SYNC + 1, 0);

        // Lock loss during STRETCH: no bit ever falls, fault counted, restart timing
        locked_i = 1'b0;
        exp_fault++;
        watch("pre_stretch", 6, SYNC + 1, NEVER, 0);
        idle(3);
        locked_i = 1'b1;
        watch("stretch_pre", 4, 0, NEVER, 0);
        locked_i = 1'b0;
        exp_fault++;
        watch("stretch_drop", 25, 0, NEVER, 0);
        check_fault("stretch fault");
        locked_i = 1'b1;
        watch("stretch_restart", 28, 0, SYNC + 1, 0);

        // Button: 3-cycle glitch, then a 10-cycle press; fault count untouched
        btn_i = 1'b1;
        watch("btn_glitch", 30, GLITCH_ABORT, 3 + BTN_LAT, 3);
        check_fault("btn_glitch fault");
        btn_i = 1'b1;
        watch("btn_press", 10 + BTN_LAT + 24, BTN_LAT, 10 + BTN_LAT, 10);
        check_fault("btn_press fault");

        // Button and lock loss together: single HOLD entry, one fault
        locked_i = 1'b0;
        btn_i    = 1'b1;
        exp_fault++;
        watch("btn_lock", 12, SYNC + 1, NEVER, 6);
        check_fault("btn_lock fault");
        idle(12);
        locked_i = 1'b1;
        watch("after_btn_lock", 28, 0, SYNC + 1, 0);
        check_fault("after_btn_lock fault");

        // Saturation: 260 lock drops, each while in STRETCH
        locked_i = 1'b0;
        exp_fault++;
        idle(6);
        for (int i = 0; i < 260; i++) begin
            locked_i = 1'b1;
            idle(4);
            locked_i = 1'b0;
            exp_fault = (exp_fault >= 255) ? 255 : exp_fault + 1;
            idle(6);
            check_fault($sformatf("sat fault #%0d", i));
        end
        check_eq("sat final", 32'(fault_cnt_o), 32'd255);

        // rst arriving on the same edge as a lock-drop abort wins
        locked_i = 1'b1;
        idle(4);
        locked_i = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(1);
        exp_fault = 0;
        check_fault("rst_prio fault");
        check_eq("rst_prio rst_o", 32'(rst_o), 32'hF);
        check_eq("rst_prio ready_o", 32'(ready_o), 32'h0);
        check_eq("rst_prio state", 32'(dut.state_r), 32'(ST_HOLD));
        rst = 1'b0;
        idle(3);
        locked_i = 1'b1;
        watch("post_rst", 28, 0, SYNC + 1, 0);
        check_fault("post_rst fault");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
